// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I-subset control unit.
//   - state_e    : controller FSM states
//   - alu_op_e   : coarse ALU operation chosen by the FSM (add / sub / funct)
//   - opcode, ALUControl and ImmSrc localparams
//   - imm_src_of : immediate-format decode from the opcode
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct
    } alu_op_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's coarse ALU operation plus instruction fields to the
// 3-bit ALUControl code of the shared ALU. Purely combinational.
// Ports:
//   alu_op      in  coarse operation (add / sub / funct)
//   funct3      in  instruction bits [14:12]
//   op5         in  opcode bit 5 (1 = R-type, distinguishes sub from addi)
//   funct7b5    in  instruction bit 30
//   alu_control out ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = AluAdd;
        unique case (alu_op)
            AluOpAdd: alu_control = AluAdd;
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // addi has no funct7, so bit 30 is immediate data unless op5 marks R-type
                    3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit of the multicycle RV32I-subset core. Sequences
// each instruction through fetch/decode/execute/memory/writeback and drives the
// datapath selects, write enables and ALUControl every cycle.
// Optional feature macro: CTRL_BNE_EN (adds bne; other branch funct3 values illegal).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   op, funct3, funct7b5   instruction fields from the IR
//   Zero                   ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, RegWrite, ImmSrc   datapath controls
//   illegal_instr          one-cycle pulse in DECODE for an unsupported instruction
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_update, branch, branch_cond, branch_ok;
    logic    mem_write, ir_write, reg_write, illegal;

`ifdef CTRL_BNE_EN
    assign branch_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_cond = (funct3 == 3'b001) ? ~Zero : Zero;
`else
    assign branch_ok   = 1'b1;
    assign branch_cond = Zero;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_op    = AluOpAdd;
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        unique case (state_q)
            StFetch: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Branch target computed now from OldPC + imm, latched in ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIAlu:          state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBranch: begin
                        if (branch_ok) begin
                            state_d = StBeq;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                state_d   = StFetch;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpSub;
                branch  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                // ALUResult = OldPC + 4 is the link value; PC takes the target from ALUOut
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            default: state_d = StFetch;
        endcase
    end

    // Architectural writes are suppressed while reset is high so an abandoned
    // instruction leaves no trace.
    assign PCWrite       = ~reset & (pc_update | (branch & branch_cond));
    assign MemWrite      = ~reset & mem_write;
    assign IRWrite       = ~reset & ir_write;
    assign RegWrite      = ~reset & reg_write;
    assign illegal_instr = ~reset & illegal;
    assign ImmSrc        = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule
